// File: rtl/butterfly_stage.sv
// Radix-2 DIF butterfly stage: registered sum and twiddled difference of SR-delayed and
// current samples, block beat tracking, and the valid window for the next SR stage.
module butterfly_stage #(
    parameter int IN_DATA_W  = 9,
    parameter int OUT_DATA_W = 10,
    parameter int UNIT_SIZE  = 16,
    parameter int BLK_LEN    = 16,
    parameter int TW_MODE    = 1,
    parameter int SAT_EN     = 1,
    parameter int SR_HOLD    = 17
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  valid_in,
    input  logic                                  blk_sync,
    input  logic [UNIT_SIZE-1:0][IN_DATA_W-1:0]   input_sr_real,
    input  logic [UNIT_SIZE-1:0][IN_DATA_W-1:0]   input_sr_imag,
    input  logic [UNIT_SIZE-1:0][IN_DATA_W-1:0]   input_org_real,
    input  logic [UNIT_SIZE-1:0][IN_DATA_W-1:0]   input_org_imag,
    output logic                                  valid_out,
    output logic                                  blk_first,
    output logic                                  blk_last,
    output logic [UNIT_SIZE-1:0][OUT_DATA_W-1:0]  output_add_real,
    output logic [UNIT_SIZE-1:0][OUT_DATA_W-1:0]  output_add_imag,
    output logic [UNIT_SIZE-1:0][OUT_DATA_W-1:0]  output_sub_real,
    output logic [UNIT_SIZE-1:0][OUT_DATA_W-1:0]  output_sub_imag,
    output logic                                  SR_valid
);
    localparam int EW = OUT_DATA_W + 1;
    localparam int IW = OUT_DATA_W + 10;
    localparam int CW = $clog2(BLK_LEN);
    localparam int SW = $clog2(SR_HOLD + 1);
    localparam logic signed [IW-1:0] K_COEF = IW'(181);
    localparam logic signed [IW-1:0] K_RND  = IW'(128);
    localparam logic signed [IW-1:0] MAX_V  = IW'((1 << (OUT_DATA_W - 1)) - 1);
    localparam logic signed [IW-1:0] MIN_V  = ~MAX_V;

    function automatic logic signed [IW-1:0] k_scale(input logic signed [IW-1:0] x);
        logic signed [IW-1:0] p;
        p = x * K_COEF + K_RND;
        return p >>> 8;
    endfunction

    function automatic logic [OUT_DATA_W-1:0] reduce(input logic signed [IW-1:0] x);
        logic signed [IW-1:0] y;
        y = x;
        if (SAT_EN != 0) begin
            if (x > MAX_V)      y = MAX_V;
            else if (x < MIN_V) y = MIN_V;
        end
        return y[OUT_DATA_W-1:0];
    endfunction

    function automatic logic signed [IW-1:0] tw_re(input logic signed [IW-1:0] dr,
                                                   input logic signed [IW-1:0] di,
                                                   input logic [1:0] q);
        case (q)
            2'd0:    return dr;
            2'd1:    return k_scale(dr + di);
            2'd2:    return di;
            default: return k_scale(di - dr);
        endcase
    endfunction

    function automatic logic signed [IW-1:0] tw_im(input logic signed [IW-1:0] dr,
                                                   input logic signed [IW-1:0] di,
                                                   input logic [1:0] q);
        case (q)
            2'd0:    return di;
            2'd1:    return k_scale(di - dr);
            2'd2:    return -dr;
            default: return k_scale(-dr - di);
        endcase
    endfunction

    logic [CW-1:0]                beat_cnt;
    logic [CW-1:0]                beat_idx;
    logic [SW-1:0]                sr_cnt;
    logic [1:0]                   q_in;
    logic                         first_in, last_in;
    logic [UNIT_SIZE-1:0][EW-1:0] ar_in, ai_in, dr_in, di_in;

    // Input stage: beat index, quarter select and full-precision sum/difference
    always_comb begin
        beat_idx = blk_sync ? '0 : beat_cnt;
        first_in = (beat_idx == '0);
        last_in  = (beat_idx == CW'(BLK_LEN - 1));
        case (TW_MODE)
            1:       q_in = {beat_idx[CW-1], 1'b0};
            2:       q_in = beat_idx[CW-1 -: 2];
            default: q_in = 2'd0;
        endcase
        for (int l = 0; l < UNIT_SIZE; l++) begin
            ar_in[l] = EW'($signed(input_sr_real[l])) + EW'($signed(input_org_real[l]));
            ai_in[l] = EW'($signed(input_sr_imag[l])) + EW'($signed(input_org_imag[l]));
            dr_in[l] = EW'($signed(input_sr_real[l])) - EW'($signed(input_org_real[l]));
            di_in[l] = EW'($signed(input_sr_imag[l])) - EW'($signed(input_org_imag[l]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            sr_cnt   <= '0;
        end else begin
            if (valid_in) beat_cnt <= beat_idx + 1'b1;
            if (valid_in)           sr_cnt <= SW'(SR_HOLD);
            else if (sr_cnt != '0)  sr_cnt <= sr_cnt - 1'b1;
        end
    end

    assign SR_valid = (sr_cnt != '0);

    logic [UNIT_SIZE-1:0][EW-1:0] ar_s, ai_s, dr_s, di_s;
    logic [1:0]                   q_s;
    logic                         vld_s, first_s, last_s;

    generate
        if (TW_MODE == 2) begin : g_p0
            logic [UNIT_SIZE-1:0][EW-1:0] ar_p0, ai_p0, dr_p0, di_p0;
            logic [1:0]                   q_p0;
            logic                         vld_p0, first_p0, last_p0;

            // Stage p0: the W8 multiply gets a cycle of its own
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p0   <= 1'b0;
                    first_p0 <= 1'b0;
                    last_p0  <= 1'b0;
                    q_p0     <= '0;
                    ar_p0    <= '0;
                    ai_p0    <= '0;
                    dr_p0    <= '0;
                    di_p0    <= '0;
                end else begin
                    vld_p0   <= valid_in;
                    first_p0 <= valid_in & first_in;
                    last_p0  <= valid_in & last_in;
                    if (valid_in) begin
                        q_p0  <= q_in;
                        ar_p0 <= ar_in;
                        ai_p0 <= ai_in;
                        dr_p0 <= dr_in;
                        di_p0 <= di_in;
                    end
                end
            end

            assign ar_s = ar_p0;
            assign ai_s = ai_p0;
            assign dr_s = dr_p0;
            assign di_s = di_p0;
            assign q_s = q_p0;
            assign vld_s = vld_p0;
            assign first_s = first_p0;
            assign last_s = last_p0;
        end else begin : g_direct
            assign ar_s = ar_in;
            assign ai_s = ai_in;
            assign dr_s = dr_in;
            assign di_s = di_in;
            assign q_s = q_in;
            assign vld_s = valid_in;
            assign first_s = valid_in & first_in;
            assign last_s = valid_in & last_in;
        end
    endgenerate

    // Output stage: twiddle, reduce to OUT_DATA_W, register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out       <= 1'b0;
            blk_first       <= 1'b0;
            blk_last        <= 1'b0;
            output_add_real <= '0;
            output_add_imag <= '0;
            output_sub_real <= '0;
            output_sub_imag <= '0;
        end else begin
            valid_out <= vld_s;
            blk_first <= vld_s & first_s;
            blk_last  <= vld_s & last_s;
            if (vld_s) begin
                for (int l = 0; l < UNIT_SIZE; l++) begin
                    output_add_real[l] <= reduce(IW'($signed(ar_s[l])));
                    output_add_imag[l] <= reduce(IW'($signed(ai_s[l])));
                    output_sub_real[l] <= reduce(tw_re(IW'($signed(dr_s[l])),
                                                       IW'($signed(di_s[l])), q_s));
                    output_sub_imag[l] <= reduce(tw_im(IW'($signed(dr_s[l])),
                                                       IW'($signed(di_s[l])), q_s));
                end
            end
        end
    end
endmodule

// File: tb/tb_butterfly_stage.sv
// Directed bench for butterfly_stage: four instances (TW_MODE 0, 1, 2 saturating,
// 2 wrapping) share one stimulus bus and are checked against hand-computed values.
module tb_butterfly_stage;
    localparam int IW = 9;
    localparam int OW = 10;
    localparam int US = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_in = 1'b0;
    logic blk_sync = 1'b0;
    logic [US-1:0][IW-1:0] sr_re, sr_im, org_re, org_im;

    logic vo0, f0, l0, s0;
    logic vo1, f1, l1, s1;
    logic vo2, f2, l2, s2;
    logic vo3, f3, l3, s3;
    logic [US-1:0][OW-1:0] ar0, ai0, sr0, si0;
    logic [US-1:0][OW-1:0] ar1, ai1, sr1, si1;
    logic [US-1:0][OW-1:0] ar2, ai2, sr2, si2;
    logic [US-1:0][OW-1:0] ar3, ai3, sr3, si3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    butterfly_stage #(.TW_MODE(0), .SAT_EN(1)) dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .blk_sync(blk_sync),
        .input_sr_real(sr_re), .input_sr_imag(sr_im),
        .input_org_real(org_re), .input_org_imag(org_im),
        .valid_out(vo0), .blk_first(f0), .blk_last(l0),
        .output_add_real(ar0), .output_add_imag(ai0),
        .output_sub_real(sr0), .output_sub_imag(si0), .SR_valid(s0));

    butterfly_stage #(.TW_MODE(1), .SAT_EN(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .blk_sync(blk_sync),
        .input_sr_real(sr_re), .input_sr_imag(sr_im),
        .input_org_real(org_re), .input_org_imag(org_im),
        .valid_out(vo1), .blk_first(f1), .blk_last(l1),
        .output_add_real(ar1), .output_add_imag(ai1),
        .output_sub_real(sr1), .output_sub_imag(si1), .SR_valid(s1));

    butterfly_stage #(.TW_MODE(2), .SAT_EN(1)) dut2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .blk_sync(blk_sync),
        .input_sr_real(sr_re), .input_sr_imag(sr_im),
        .input_org_real(org_re), .input_org_imag(org_im),
        .valid_out(vo2), .blk_first(f2), .blk_last(l2),
        .output_add_real(ar2), .output_add_imag(ai2),
        .output_sub_real(sr2), .output_sub_imag(si2), .SR_valid(s2));

    butterfly_stage #(.TW_MODE(2), .SAT_EN(0)) dut3 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .blk_sync(blk_sync),
        .input_sr_real(sr_re), .input_sr_imag(sr_im),
        .input_org_real(org_re), .input_org_imag(org_im),
        .valid_out(vo3), .blk_first(f3), .blk_last(l3),
        .output_add_real(ar3), .output_add_imag(ai3),
        .output_sub_real(sr3), .output_sub_imag(si3), .SR_valid(s3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int a_r, input int a_i, input int b_r, input int b_i);
        for (int l = 0; l < US; l++) begin
            sr_re[l]  = IW'(a_r);
            sr_im[l]  = IW'(a_i);
            org_re[l] = IW'(b_r);
            org_im[l] = IW'(b_i);
        end
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        blk_sync = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({vo0, vo1, vo2, vo3, f0, f1, f2, f3, l0, l1, l2, l3} !== 12'h0)
            $display("FAIL reset_flags got=%b want=0", {vo0, vo1, vo2, vo3, f0, f1, f2, f3, l0, l1, l2, l3});
        total++;
        if ({s0, s1, s2, s3} !== 4'h0) $display("FAIL reset_srvalid got=%b want=0000", {s0, s1, s2, s3});
        if ({s0, s1, s2, s3} !== 4'h0) bad++;
        if ({vo0, vo1, vo2, vo3, f0, f1, f2, f3, l0, l1, l2, l3} !== 12'h0) bad++;
        tick();
        total++;
        if ({ar0, ai0, sr0, si0, ar2, ai2, sr2, si2} !== '0) begin
            bad++;
            $display("FAIL reset_data got=nonzero want=0");
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int gr, gi;
        set_in(100, -3, 20, 5);
        sr_re[7] = IW'(-256); org_re[7] = IW'(255);
        sr_im[7] = '0;        org_im[7] = '0;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        set_in(0, 0, 0, 0);
        total++; if (vo0 !== 1'b1) begin bad++; $display("FAIL basic_vo got=%b want=1", vo0); end
        gr = int'($signed(ar0[0])); gi = int'($signed(ai0[0]));
        total++; if (gr !== 120 || gi !== 2) begin bad++; $display("FAIL basic_add got=(%0d,%0d) want=(120,2)", gr, gi); end
        gr = int'($signed(sr0[0])); gi = int'($signed(si0[0]));
        total++; if (gr !== 80 || gi !== -8) begin bad++; $display("FAIL basic_sub got=(%0d,%0d) want=(80,-8)", gr, gi); end
        gr = int'($signed(ar0[7])); gi = int'($signed(sr0[7]));
        total++; if (gr !== -1 || gi !== -511) begin bad++; $display("FAIL lane7 add_re/sub_re got=(%0d,%0d) want=(-1,-511)", gr, gi); end
        total++; if (f0 !== 1'b1 || l0 !== 1'b0) begin bad++; $display("FAIL basic_flags got=(%b,%b) want=(1,0)", f0, l0); end
        total++; if (vo2 !== 1'b0) begin bad++; $display("FAIL mode2_early got=%b want=0", vo2); end
        tick();
        total++; if (vo2 !== 1'b1 || f2 !== 1'b1) begin bad++; $display("FAIL mode2_vo got=(%b,%b) want=(1,1)", vo2, f2); end
        gr = int'($signed(sr2[0])); gi = int'($signed(si2[0]));
        total++; if (gr !== 80 || gi !== -8) begin bad++; $display("FAIL mode2_sub_q0 got=(%0d,%0d) want=(80,-8)", gr, gi); end
        gr = int'($signed(ar2[0])); gi = int'($signed(ai2[0]));
        total++; if (gr !== 120 || gi !== 2) begin bad++; $display("FAIL mode2_add got=(%0d,%0d) want=(120,2)", gr, gi); end
        gr = int'($signed(sr0[0])); gi = int'($signed(si0[0]));
        total++; if (vo0 !== 1'b0 || f0 !== 1'b0 || gr !== 80 || gi !== -8)
            begin bad++; $display("FAIL hold got vo=%b f=%b sub=(%0d,%0d) want vo=0 f=0 sub=(80,-8)", vo0, f0, gr, gi); end
    endtask

    task automatic test_mode1_wrap();
        int gr, gi, er, ei, b;
        do_reset();
        set_in(100, -3, 20, 5);
        for (int i = 0; i < 32; i++) begin
            valid_in = 1'b1;
            tick();
            b = i % 16;
            er = (b < 8) ? 80 : -8;
            ei = (b < 8) ? -8 : -80;
            gr = int'($signed(sr1[0])); gi = int'($signed(si1[0]));
            total++;
            if (vo1 !== 1'b1 || gr !== er || gi !== ei) begin
                bad++; $display("FAIL mode1_sub beat=%0d got vo=%b (%0d,%0d) want vo=1 (%0d,%0d)", i, vo1, gr, gi, er, ei);
            end
            total++;
            if (f1 !== (b == 0) || l1 !== (b == 15)) begin
                bad++; $display("FAIL mode1_flags beat=%0d got=(%b,%b) want=(%b,%b)", i, f1, l1, b == 0, b == 15);
            end
        end
        valid_in = 1'b0;
        tick();
        total++; if (vo1 !== 1'b0 || f1 !== 1'b0 || l1 !== 1'b0)
            begin bad++; $display("FAIL mode1_idle got=(%b,%b,%b) want=(0,0,0)", vo1, f1, l1); end
    endtask

    task automatic test_mode2();
        int gr, gi, er, ei, b;
        do_reset();
        set_in(100, 10, 20, 10);
        for (int i = 0; i < 4; i++) begin valid_in = 1'b1; tick(); end
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        gr = int'($signed(sr2[0])); gi = int'($signed(si2[0]));
        total++; if (vo2 !== 1'b0 || gr !== 80 || gi !== 0)
            begin bad++; $display("FAIL q1_latency got vo=%b (%0d,%0d) want vo=0 (80,0)", vo2, gr, gi); end
        tick();
        gr = int'($signed(sr2[0])); gi = int'($signed(si2[0]));
        total++; if (vo2 !== 1'b1 || gr !== 57 || gi !== -57)
            begin bad++; $display("FAIL q1_round got vo=%b (%0d,%0d) want vo=1 (57,-57)", vo2, gr, gi); end
        gr = int'($signed(sr3[0])); gi = int'($signed(ar3[0]));
        total++; if (gr !== 57 || gi !== 120)
            begin bad++; $display("FAIL q1_wrapinst sub_re/add_re got=(%0d,%0d) want=(57,120)", gr, gi); end
        for (int j = 5; j <= 16; j++) begin
            valid_in = (j < 16);
            tick();
            if (j > 5) begin
                b = j - 1;
                case (b / 4)
                    1:       begin er = 57;  ei = -57; end
                    2:       begin er = 0;   ei = -80; end
                    default: begin er = -57; ei = -57; end
                endcase
                gr = int'($signed(sr2[0])); gi = int'($signed(si2[0]));
                total++;
                if (vo2 !== 1'b1 || gr !== er || gi !== ei || l2 !== (b == 15)) begin
                    bad++; $display("FAIL mode2_beat=%0d got vo=%b last=%b (%0d,%0d) want (%0d,%0d)", b, vo2, l2, gr, gi, er, ei);
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_saturation();
        int gr, gi;
        do_reset();
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin valid_in = 1'b1; tick(); end
        set_in(255, 255, -256, -256);
        tick();
        gr = int'($signed(sr0[0])); gi = int'($signed(si0[0]));
        total++; if (gr !== 511 || gi !== 511) begin bad++; $display("FAIL sat_mode0 got=(%0d,%0d) want=(511,511)", gr, gi); end
        set_in(-256, -256, 255, 255);
        tick();
        valid_in = 1'b0;
        gr = int'($signed(sr2[0])); gi = int'($signed(si2[0]));
        total++; if (gr !== 511 || gi !== 0) begin bad++; $display("FAIL sat_pos got=(%0d,%0d) want=(511,0)", gr, gi); end
        gr = int'($signed(sr3[0])); gi = int'($signed(si3[0]));
        total++; if (gr !== -301 || gi !== 0) begin bad++; $display("FAIL wrap_pos got=(%0d,%0d) want=(-301,0)", gr, gi); end
        gr = int'($signed(ar2[0])); gi = int'($signed(ai2[0]));
        total++; if (gr !== -1 || gi !== -1) begin bad++; $display("FAIL sat_add got=(%0d,%0d) want=(-1,-1)", gr, gi); end
        tick();
        gr = int'($signed(sr2[0])); gi = int'($signed(sr3[0]));
        total++; if (gr !== -512 || gi !== 301) begin bad++; $display("FAIL sat_neg sat/wrap got=(%0d,%0d) want=(-512,301)", gr, gi); end
    endtask

    task automatic test_sync_gaps();
        int gr, gi;
        do_reset();
        set_in(100, -3, 20, 5);
        for (int i = 0; i < 10; i++) begin valid_in = 1'b1; tick(); end
        valid_in = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tick();
            total++; if (vo1 !== 1'b0 || f1 !== 1'b0 || l1 !== 1'b0)
                begin bad++; $display("FAIL gap=%0d got=(%b,%b,%b) want=(0,0,0)", g, vo1, f1, l1); end
        end
        valid_in = 1'b1;
        blk_sync = 1'b1;
        tick();
        valid_in = 1'b0;
        blk_sync = 1'b0;
        gr = int'($signed(sr1[0])); gi = int'($signed(si1[0]));
        total++; if (vo1 !== 1'b1 || f1 !== 1'b1 || gr !== 80 || gi !== -8)
            begin bad++; $display("FAIL sync_mode1 got vo=%b f=%b (%0d,%0d) want vo=1 f=1 (80,-8)", vo1, f1, gr, gi); end
        tick();
        gr = int'($signed(sr2[0])); gi = int'($signed(si2[0]));
        total++; if (vo2 !== 1'b1 || f2 !== 1'b1 || gr !== 80 || gi !== -8)
            begin bad++; $display("FAIL sync_mode2 got vo=%b f=%b (%0d,%0d) want vo=1 f=1 (80,-8)", vo2, f2, gr, gi); end
        blk_sync = 1'b1;
        tick();
        blk_sync = 1'b0;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        total++; if (vo1 !== 1'b1 || f1 !== 1'b0)
            begin bad++; $display("FAIL sync_ignored got vo=%b f=%b want vo=1 f=0", vo1, f1); end
    endtask

    task automatic test_sr_valid();
        int n;
        do_reset();
        set_in(100, -3, 20, 5);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin if (s0 === 1'b1) n++; tick(); end
        total++; if (n !== 17) begin bad++; $display("FAIL srv_single got=%0d want=17", n); end
        valid_in = 1'b1;
        tick();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (s0 === 1'b1) n++;
            valid_in = (k == 4);
            tick();
        end
        total++; if (n !== 22) begin bad++; $display("FAIL srv_extend got=%0d want=22", n); end
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        total++; if (s0 !== 1'b1 || vo0 !== 1'b1) begin bad++; $display("FAIL srv_pre_rst got=(%b,%b) want=(1,1)", s0, vo0); end
        rst = 1'b1;
        #1;
        total++; if (s0 !== 1'b0 || s2 !== 1'b0 || vo0 !== 1'b0 || ar0 !== '0)
            begin bad++; $display("FAIL async_rst got srv=%b/%b vo=%b want 0/0/0", s0, s2, vo0); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (vo2 !== 1'b0) begin bad++; $display("FAIL inflight_discard got=%b want=0", vo2); end
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        total++; if (vo1 !== 1'b1 || f1 !== 1'b1) begin bad++; $display("FAIL post_rst_beat0 got=(%b,%b) want=(1,1)", vo1, f1); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        set_in(0, 0, 0, 0);
        test_reset();
        test_basic();
        test_mode1_wrap();
        test_mode2();
        test_saturation();
        test_sync_gaps();
        test_sr_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
